// File: rtl/axa_pkg.sv
// Shared AXA pipeline constants: undo-stack word/depth sizing and IL operand type encodings.
package axa_pkg;

   localparam int WORD  = 16;
   localparam int UPTR  = 4;
   localparam int USIZE = 16;

   typedef enum logic [1:0] {
      ILTypeReg = 2'b00,
      ILTypeImm = 2'b01,
      ILTypeMem = 2'b10,
      ILTypeUnd = 2'b11
   } il_type_e;

   typedef enum logic {
      SCRUB = 1'b0,
      IDLE  = 1'b1
   } und_state_e;

endpackage

// File: rtl/axa_undo_ram.sv
// Undo-stack register array: one write port shared by push and scrub, two asynchronous read ports.
module axa_undo_ram
   import axa_pkg::*;
#(
   parameter int WIDTH = WORD,
   parameter int DEPTH = USIZE,
   parameter int PTRW  = UPTR
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTRW-1:0]  waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTRW-1:0]  raddr_a,
   output logic [WIDTH-1:0] rdata_a,
   input  logic [PTRW-1:0]  raddr_b,
   output logic [WIDTH-1:0] rdata_b
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: no reset on the array; the scrub pass zeroes it, keeping it a plain register file.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/axa_undo_buffer.sv
// Circular undo-stack responder: push/pop/peek on a wrapping ring, scrubbed on reset and flush.
module axa_undo_buffer
   import axa_pkg::*;
#(
   parameter int WIDTH = WORD,
   parameter int DEPTH = USIZE,
   parameter int PTRW  = UPTR
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             pop_valid,
   input  logic             peek,
   input  logic [PTRW-1:0]  peek_off,
   output logic [WIDTH-1:0] peek_data,
   output logic             peek_valid,
   input  logic             flush,
   output logic             busy,
   output logic [PTRW:0]    count,
   output logic             lost,
   output logic             underflow
);

   localparam logic [PTRW:0]   FULL     = (PTRW+1)'(DEPTH);
   localparam logic [PTRW-1:0] LAST_IDX = PTRW'(DEPTH - 1);

   und_state_e       state_q, state_d;
   logic [PTRW-1:0]  sp_q, sp_d, idx_q, idx_d;
   logic [PTRW:0]    cnt_q, cnt_d;
   logic             lost_d;
   logic [WIDTH-1:0] pop_data_d, peek_data_d;
   logic             pop_valid_d, peek_valid_d, underflow_d;

   logic             we;
   logic [PTRW-1:0]  waddr, sp_m1, peek_addr;
   logic [WIDTH-1:0] wdata, rdata_a, rdata_b;
   logic             empty, full;

   assign sp_m1     = sp_q - 1'b1;
   assign peek_addr = sp_m1 - peek_off;
   assign empty     = (cnt_q == '0);
   assign full      = (cnt_q == FULL);

   axa_undo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTRW(PTRW)) u_ram (
      .clk     (clk),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .raddr_a (sp_m1),
      .rdata_a (rdata_a),
      .raddr_b (peek_addr),
      .rdata_b (rdata_b)
   );

   // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      sp_d         = sp_q;
      cnt_d        = cnt_q;
      lost_d       = lost;
      pop_data_d   = pop_data;
      peek_data_d  = peek_data;
      pop_valid_d  = 1'b0;
      peek_valid_d = 1'b0;
      underflow_d  = 1'b0;
      we           = 1'b0;
      waddr        = sp_q;
      wdata        = push_data;

      case (state_q)
         SCRUB: begin
            we    = 1'b1;
            waddr = idx_q;
            wdata = '0;
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) state_d = IDLE;
         end

         IDLE: begin
            if (flush) begin
               sp_d    = '0;
               cnt_d   = '0;
               lost_d  = 1'b0;
               idx_d   = '0;
               state_d = SCRUB;
            end else begin
               if (pop) begin
                  pop_valid_d = 1'b1;
                  if (empty) begin
                     pop_data_d  = '0;
                     underflow_d = 1'b1;
                  end else begin
                     pop_data_d = rdata_a;
                  end
               end

               // A combined push/pop on a non-empty stack replaces the top in place.
               if (push && pop && !empty) begin
                  we    = 1'b1;
                  waddr = sp_m1;
               end else if (push) begin
                  we   = 1'b1;
                  sp_d = sp_q + 1'b1;
                  if (full) lost_d = 1'b1;
                  else      cnt_d  = cnt_q + 1'b1;
               end else if (pop && !empty) begin
                  sp_d  = sp_m1;
                  cnt_d = cnt_q - 1'b1;
               end

               if (peek) begin
                  peek_valid_d = 1'b1;
                  if ({1'b0, peek_off} < cnt_q) begin
                     peek_data_d = rdata_b;
                  end else begin
                     peek_data_d = '0;
                     underflow_d = 1'b1;
                  end
               end
            end
         end

         default: state_d = SCRUB;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignment so all registers sample pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= SCRUB;
         idx_q      <= '0;
         sp_q       <= '0;
         cnt_q      <= '0;
         lost       <= 1'b0;
         pop_data   <= '0;
         pop_valid  <= 1'b0;
         peek_data  <= '0;
         peek_valid <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         sp_q       <= sp_d;
         cnt_q      <= cnt_d;
         lost       <= lost_d;
         pop_data   <= pop_data_d;
         pop_valid  <= pop_valid_d;
         peek_data  <= peek_data_d;
         peek_valid <= peek_valid_d;
         underflow  <= underflow_d;
      end
   end

   assign busy  = (state_q == SCRUB);
   assign count = cnt_q;

endmodule

// File: tb/tb_axa_undo_buffer.sv
// Directed bench for axa_undo_buffer: a vector table for single-cycle behaviour plus scrub/flush/reset sequences.
module tb_axa_undo_buffer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        push = 1'b0;
   logic [15:0] push_data = '0;
   logic        pop = 1'b0;
   logic [15:0] pop_data;
   logic        pop_valid;
   logic        peek = 1'b0;
   logic [3:0]  peek_off = '0;
   logic [15:0] peek_data;
   logic        peek_valid;
   logic        flush = 1'b0;
   logic        busy;
   logic [4:0]  count;
   logic        lost;
   logic        underflow;

   int n_checks = 0;
   int n_fail   = 0;

   axa_undo_buffer dut (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_data  (push_data),
      .pop        (pop),
      .pop_data   (pop_data),
      .pop_valid  (pop_valid),
      .peek       (peek),
      .peek_off   (peek_off),
      .peek_data  (peek_data),
      .peek_valid (peek_valid),
      .flush      (flush),
      .busy       (busy),
      .count      (count),
      .lost       (lost),
      .underflow  (underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        push;
      logic [15:0] pd;
      logic        pop;
      logic        peek;
      logic [3:0]  off;
      logic        e_pv;
      logic [15:0] e_pdat;
      logic        e_kv;
      logic [15:0] e_kdat;
      logic [4:0]  e_cnt;
      logic        e_uf;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one request cycle, then sample 1 time unit after the edge.
   task automatic cyc(input logic pu, input logic [15:0] pd, input logic po,
                      input logic pk, input logic [3:0] off, input logic fl);
      push = pu; push_data = pd; pop = po; peek = pk; peek_off = off; flush = fl;
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0; peek = 1'b0; flush = 1'b0;
   endtask

   // Counts edges until busy drops, bounded so a stuck scrub cannot hang the run.
   task automatic wait_busy(output int n);
      n = 0;
      while (busy && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " busy"},       busy,       1'b1);
      check({tag, " count"},      count,      5'd0);
      check({tag, " lost"},       lost,       1'b0);
      check({tag, " pop_valid"},  pop_valid,  1'b0);
      check({tag, " peek_valid"}, peek_valid, 1'b0);
      check({tag, " underflow"},  underflow,  1'b0);
      check({tag, " pop_data"},   pop_data,   16'h0);
      check({tag, " peek_data"},  peek_data,  16'h0);
   endtask

   initial begin
      int n;

      //                push  data      pop   peek  off   pv    pdat      kv    kdat      cnt   uf
      vecs[0]  = '{1'b1, 16'h1111, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd1, 1'b0};
      vecs[1]  = '{1'b1, 16'h2222, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd2, 1'b0};
      vecs[2]  = '{1'b1, 16'h3333, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd3, 1'b0};
      vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd2, 1'b0, 16'h0000, 1'b1, 16'h1111, 5'd3, 1'b0};
      vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 16'h3333, 1'b0, 16'h0000, 5'd2, 1'b0};
      vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 16'h2222, 1'b0, 16'h0000, 5'd1, 1'b0};
      vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b1, 16'h1111, 5'd1, 1'b0};
      vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd1, 1'b0, 16'h0000, 1'b1, 16'h0000, 5'd1, 1'b1};
      vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 16'h1111, 1'b0, 16'h0000, 5'd0, 1'b0};
      vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd0, 1'b1, 16'h0000, 1'b1, 16'h0000, 5'd0, 1'b1};
      vecs[10] = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 16'h0000, 5'd1, 1'b0};
      vecs[11] = '{1'b1, 16'hBBBB, 1'b1, 1'b0, 4'd0, 1'b1, 16'hAAAA, 1'b0, 16'h0000, 5'd1, 1'b0};
      vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 16'hBBBB, 1'b0, 16'h0000, 5'd0, 1'b0};
      vecs[13] = '{1'b1, 16'hCCCC, 1'b1, 1'b0, 4'd0, 1'b1, 16'h0000, 1'b0, 16'h0000, 5'd1, 1'b1};
      vecs[14] = '{1'b1, 16'hDDDD, 1'b0, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b1, 16'hCCCC, 5'd2, 1'b0};
      vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b1, 16'hDDDD, 5'd2, 1'b0};
      vecs[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd1, 1'b1, 16'hDDDD, 1'b1, 16'hCCCC, 5'd1, 1'b0};
      vecs[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 16'hCCCC, 1'b0, 16'h0000, 5'd0, 1'b0};

      // Power-on reset and initial scrub.
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("reset");
      reset = 1'b0;
      wait_busy(n);
      check("reset scrub length", n, 16);
      cyc(1'b0, 16'h0, 1'b0, 1'b1, 4'd0, 1'b0);
      check("empty peek valid", peek_valid, 1'b1);
      check("empty peek data",  peek_data,  16'h0);
      check("empty peek uf",    underflow,  1'b1);

      for (int i = 0; i < 18; i++) begin
         cyc(vecs[i].push, vecs[i].pd, vecs[i].pop, vecs[i].peek, vecs[i].off, 1'b0);
         check($sformatf("v%0d pop_valid", i),  pop_valid,  vecs[i].e_pv);
         check($sformatf("v%0d peek_valid", i), peek_valid, vecs[i].e_kv);
         check($sformatf("v%0d count", i),      count,      vecs[i].e_cnt);
         check($sformatf("v%0d underflow", i),  underflow,  vecs[i].e_uf);
         check($sformatf("v%0d lost", i),       lost,       1'b0);
         if (vecs[i].e_pv) check($sformatf("v%0d pop_data", i),  pop_data,  vecs[i].e_pdat);
         if (vecs[i].e_kv) check($sformatf("v%0d peek_data", i), peek_data, vecs[i].e_kdat);
      end

      // Overfill: 17 pushes lose the oldest word.
      for (int i = 0; i < 17; i++) begin
         cyc(1'b1, 16'(i), 1'b0, 1'b0, 4'd0, 1'b0);
         if (i == 15) begin
            check("full count", count, 5'd16);
            check("full lost",  lost,  1'b0);
         end
      end
      check("overfill count", count, 5'd16);
      check("overfill lost",  lost,  1'b1);
      cyc(1'b0, 16'h0, 1'b0, 1'b1, 4'd15, 1'b0);
      check("peek off15 data", peek_data, 16'h0001);
      check("peek off15 uf",   underflow, 1'b0);
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 16'h0, 1'b1, 1'b0, 4'd0, 1'b0);
         check($sformatf("drain pop %0d data", i), pop_data, 16'(16 - i));
         check($sformatf("drain pop %0d uf", i),   underflow, 1'b0);
      end
      check("drained count", count, 5'd0);
      cyc(1'b0, 16'h0, 1'b1, 1'b0, 4'd0, 1'b0);
      check("extra pop valid", pop_valid, 1'b1);
      check("extra pop data",  pop_data,  16'h0);
      check("extra pop uf",    underflow, 1'b1);
      check("lost sticky",     lost,      1'b1);

      // Flush: history discarded, requests during scrub dropped.
      cyc(1'b1, 16'h5555, 1'b0, 1'b0, 4'd0, 1'b0);
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b1);
      check("flush busy",  busy,  1'b1);
      check("flush count", count, 5'd0);
      check("flush lost",  lost,  1'b0);
      cyc(1'b1, 16'h7777, 1'b1, 1'b1, 4'd0, 1'b0);
      check("busy drop count",      count,      5'd0);
      check("busy drop peek_valid", peek_valid, 1'b0);
      check("busy drop pop_valid",  pop_valid,  1'b0);
      check("busy drop uf",         underflow,  1'b0);
      wait_busy(n);
      check("flush scrub length", n + 1, 16);
      check("post flush count", count, 5'd0);
      cyc(1'b0, 16'h0, 1'b0, 1'b1, 4'd0, 1'b0);
      check("post flush peek data", peek_data, 16'h0);
      check("post flush peek uf",   underflow, 1'b1);

      // Reset in the middle of a scrub restarts it.
      cyc(1'b1, 16'h1234, 1'b0, 1'b0, 4'd0, 1'b0);
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 4'd0, 1'b1);
      repeat (5) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      check_reset_vals("mid-scrub reset");
      reset = 1'b0;
      wait_busy(n);
      check("restart scrub length", n, 16);
      cyc(1'b0, 16'h0, 1'b1, 1'b0, 4'd0, 1'b0);
      check("restart pop data", pop_data,  16'h0);
      check("restart pop uf",   underflow, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
